// File: rtl/multichannel_counter_bank_pkg.sv
// Shared constants for the multichannel counter bank: terminal modes, count
// directions, per-channel FSM encodings and the channel-select width helper.
package ctr_bank_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/multichannel_counter_bank_if.sv
// Channel-addressed configuration write bus for the counter bank.
interface multichannel_counter_bank_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned CH = 4
);
    localparam int unsigned CH_W = ctr_bank_pkg::ch_width(CH);

    logic            cfg_we;
    logic [CH_W-1:0] cfg_ch;
    logic [N-1:0]    cfg_limit;
    logic [1:0]      cfg_mode;
    logic            cfg_dir;

    modport master (output cfg_we, cfg_ch, cfg_limit, cfg_mode, cfg_dir);
    modport slave  (input  cfg_we, cfg_ch, cfg_limit, cfg_mode, cfg_dir);

endinterface

// File: rtl/multichannel_counter_bank_channel.sv
// One counter channel: up/down count with limit, wrap/saturate/one-shot
// terminal behaviour, registered expiry pulse and sticky flag.
module counter_channel
    import ctr_bank_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_sel,
    input  logic [N-1:0] cfg_limit,
    input  logic [1:0]   cfg_mode,
    input  logic         cfg_dir,
    input  logic         en,
    input  logic         pause,
    input  logic         clr_expired,
    output logic [N-1:0] count,
    output logic         expired_pulse,
    output logic         expired_sticky,
    output logic         running_c
);

    localparam logic [N:0]   STEP_X = (N+1)'(STEP);
    localparam logic [N-1:0] STEP_N = N'(STEP);

    logic [N-1:0] count_q, count_d;
    logic [N-1:0] limit_q, limit_d;
    logic [1:0]   mode_q, mode_d;
    logic         dir_q, dir_d;
    logic [0:0]   state_q, state_d;
    logic         pulse_q, pulse_d;
    logic         sticky_q, sticky_d;
    logic         counting_c;
    logic         terminal_c;

    // Terminal test is done one bit wider so count+STEP cannot overflow.
    always_comb begin
        counting_c = (state_q == ST_RUN) && en && !pause;
        if (dir_q == DIR_DN) terminal_c = {1'b0, count_q} < STEP_X;
        else                 terminal_c = ({1'b0, count_q} + STEP_X) > {1'b0, limit_q};
    end

    always_comb begin
        count_d  = count_q;
        limit_d  = limit_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        state_d  = state_q;
        pulse_d  = 1'b0;
        sticky_d = clr_expired ? 1'b0 : sticky_q;

        if (cfg_sel) begin
            limit_d = cfg_limit;
            mode_d  = cfg_mode;
            dir_d   = cfg_dir;
            count_d = cfg_dir ? cfg_limit : '0;
            state_d = ST_RUN;
        end else if (counting_c) begin
            if (terminal_c) begin
                pulse_d  = 1'b1;
                sticky_d = 1'b1;
                if (mode_q == MODE_SAT || mode_q == MODE_ONESHOT)
                    count_d = (dir_q == DIR_DN) ? '0 : limit_q;
                else
                    count_d = (dir_q == DIR_DN) ? limit_q : '0;
                if (mode_q == MODE_ONESHOT) state_d = ST_DONE;
            end else if (dir_q == DIR_DN) begin
                count_d = count_q - STEP_N;
            end else begin
                count_d = count_q + STEP_N;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            limit_q  <= '1;
            mode_q   <= MODE_WRAP;
            dir_q    <= DIR_UP;
            state_q  <= ST_RUN;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            limit_q  <= limit_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
        end
    end

    assign count          = count_q;
    assign expired_pulse  = pulse_q;
    assign expired_sticky = sticky_q;
    assign running_c      = counting_c;

endmodule

// File: rtl/multichannel_counter_bank.sv
// Bank of CH independent counters sharing one channel-addressed config port;
// decodes the config target and flattens per-channel outputs.
module multichannel_counter_bank
    import ctr_bank_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned CH   = 4,
    parameter int unsigned STEP = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multichannel_counter_bank_if.slave cfg_bus,
    input  logic [CH-1:0]              en,
    input  logic [CH-1:0]              pause,
    input  logic [CH-1:0]              clr_expired,
    output logic [CH*N-1:0]            count,
    output logic [CH-1:0]              expired_pulse,
    output logic [CH-1:0]              expired_sticky,
    output logic [CH-1:0]              running
);

    localparam int unsigned CH_W = ch_width(CH);

    logic [CH-1:0] cfg_sel_c;

    // Out-of-range channel numbers match no channel and are dropped.
    always_comb begin
        cfg_sel_c = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (cfg_bus.cfg_we && (cfg_bus.cfg_ch == CH_W'(i))) cfg_sel_c[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        counter_channel #(
            .N    (N),
            .STEP (STEP)
        ) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .cfg_sel        (cfg_sel_c[g]),
            .cfg_limit      (cfg_bus.cfg_limit),
            .cfg_mode       (cfg_bus.cfg_mode),
            .cfg_dir        (cfg_bus.cfg_dir),
            .en             (en[g]),
            .pause          (pause[g]),
            .clr_expired    (clr_expired[g]),
            .count          (count[g*N +: N]),
            .expired_pulse  (expired_pulse[g]),
            .expired_sticky (expired_sticky[g]),
            .running_c      (running[g])
        );
    end

endmodule

// File: tb/tb_multichannel_counter_bank.sv
// Scoreboard bench for multichannel_counter_bank: bank A (CH=3, STEP=1) and
// bank B (CH=2, STEP=3) driven with directed vectors.
module tb_multichannel_counter_bank;
    import ctr_bank_pkg::*;

    localparam int unsigned N   = 8;
    localparam int unsigned CHA = 3;
    localparam int unsigned CHB = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multichannel_counter_bank_if #(.N(N), .CH(CHA)) if_a ();
    multichannel_counter_bank_if #(.N(N), .CH(CHB)) if_b ();

    logic [CHA-1:0]   en_a, pause_a, clr_a, pulse_a, sticky_a, run_a;
    logic [CHA*N-1:0] count_a;
    logic [CHB-1:0]   en_b, pause_b, clr_b, pulse_b, sticky_b, run_b;
    logic [CHB*N-1:0] count_b;

    multichannel_counter_bank #(.N(N), .CH(CHA), .STEP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_bus(if_a),
        .en(en_a), .pause(pause_a), .clr_expired(clr_a),
        .count(count_a), .expired_pulse(pulse_a), .expired_sticky(sticky_a), .running(run_a)
    );

    multichannel_counter_bank #(.N(N), .CH(CHB), .STEP(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_bus(if_b),
        .en(en_b), .pause(pause_b), .clr_expired(clr_b),
        .count(count_b), .expired_pulse(pulse_b), .expired_sticky(sticky_b), .running(run_b)
    );

    typedef struct {
        int         cyc;
        int         d;
        int         ch;
        logic [7:0] cnt;
        logic       pulse;
        logic       sticky;
        logic       run;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: after each edge, compare every entry scheduled for this cycle.
    initial begin
        exp_t       e;
        logic [7:0] c;
        logic       p, s, r;
        string      tag;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                tag = $sformatf("d%0d ch%0d cyc%0d", e.d, e.ch, e.cyc);
                if (e.cyc < cyc) chk({tag, " stale"}, 32'(cyc), 32'(e.cyc));
                if (e.d == 0) begin
                    c = count_a[e.ch*N +: N]; p = pulse_a[e.ch];
                    s = sticky_a[e.ch];       r = run_a[e.ch];
                end else begin
                    c = count_b[e.ch*N +: N]; p = pulse_b[e.ch];
                    s = sticky_b[e.ch];       r = run_b[e.ch];
                end
                chk({tag, " count"},   32'(c), 32'(e.cnt));
                chk({tag, " pulse"},   32'(p), 32'(e.pulse));
                chk({tag, " sticky"},  32'(s), 32'(e.sticky));
                chk({tag, " running"}, 32'(r), 32'(e.run));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ex(input int d, input int ch, input int cnt, input bit p, input bit s, input bit r);
        exp_t e;
        e = '{cyc + 1, d, ch, 8'(cnt), p, s, r};
        sb.push_back(e);
    endtask

    task automatic cfg_a(input int ch, input int lim, input logic [1:0] mode, input logic dir);
        if_a.cfg_we = 1'b1; if_a.cfg_ch = 2'(ch); if_a.cfg_limit = 8'(lim);
        if_a.cfg_mode = mode; if_a.cfg_dir = dir;
    endtask

    task automatic cfg_b(input int ch, input int lim, input logic [1:0] mode, input logic dir);
        if_b.cfg_we = 1'b1; if_b.cfg_ch = 1'(ch); if_b.cfg_limit = 8'(lim);
        if_b.cfg_mode = mode; if_b.cfg_dir = dir;
    endtask

    initial begin
        int up_v[5];
        int dn_v[5];
        up_v = '{1, 2, 3, 4, 0};
        dn_v = '{3, 2, 1, 0, 4};

        rst_n = 1'b0;
        en_a = '0; pause_a = '0; clr_a = '0;
        en_b = '0; pause_b = '0; clr_b = '0;
        if_a.cfg_we = 1'b0; if_a.cfg_ch = '0; if_a.cfg_limit = '0; if_a.cfg_mode = '0; if_a.cfg_dir = 1'b0;
        if_b.cfg_we = 1'b0; if_b.cfg_ch = '0; if_b.cfg_limit = '0; if_b.cfg_mode = '0; if_b.cfg_dir = 1'b0;
        #17 rst_n = 1'b1;

        // Reset state
        chk("reset count_a", 32'(count_a), 32'd0);
        chk("reset count_b", 32'(count_b), 32'd0);
        chk("reset pulse_a", 32'(pulse_a), 32'd0);
        chk("reset sticky_a", 32'(sticky_a), 32'd0);
        tick();

        // Out-of-range cfg_ch: nothing changes; ch2 still counts with reset defaults
        cfg_a(3, 7, MODE_SAT, DIR_DN);
        for (int i = 0; i < 3; i++) ex(0, i, 0, 0, 0, 0);
        tick();
        if_a.cfg_we = 1'b0;
        en_a = 3'b100;
        ex(0, 2, 1, 0, 0, 1); tick();
        en_a = 3'b000;
        ex(0, 2, 1, 0, 0, 0); tick();

        // Opposite directions on ch0/ch1 simultaneously
        cfg_a(0, 4, MODE_WRAP, DIR_UP);
        ex(0, 0, 0, 0, 0, 0); tick();
        cfg_a(1, 4, MODE_WRAP, DIR_DN);
        ex(0, 0, 0, 0, 0, 0); ex(0, 1, 4, 0, 0, 0); tick();
        if_a.cfg_we = 1'b0;
        en_a = 3'b011;
        for (int k = 0; k < 5; k++) begin
            ex(0, 0, up_v[k], k == 4, k == 4, 1);
            ex(0, 1, dn_v[k], k == 4, k == 4, 1);
            tick();
        end
        en_a = 3'b000; clr_a = 3'b011;
        ex(0, 0, 0, 0, 0, 0); ex(0, 1, 4, 0, 0, 0); tick();
        clr_a = 3'b000;

        // WRAP up, limit 5
        cfg_a(0, 5, MODE_WRAP, DIR_UP);
        ex(0, 0, 0, 0, 0, 0); tick();
        if_a.cfg_we = 1'b0;
        en_a = 3'b001;
        for (int k = 1; k <= 5; k++) begin ex(0, 0, k, 0, 0, 1); tick(); end
        ex(0, 0, 0, 1, 1, 1); tick();
        ex(0, 0, 1, 0, 1, 1); tick();
        en_a = 3'b000;
        ex(0, 0, 1, 0, 1, 0); tick();
        clr_a = 3'b001;
        ex(0, 0, 1, 0, 0, 0); tick();
        clr_a = 3'b000;

        // pause overrides en
        cfg_a(1, 9, MODE_WRAP, DIR_UP);
        ex(0, 1, 0, 0, 0, 0); tick();
        if_a.cfg_we = 1'b0;
        en_a = 3'b010; pause_a = 3'b010;
        ex(0, 1, 0, 0, 0, 0); tick();
        ex(0, 1, 0, 0, 0, 0); tick();
        pause_a = 3'b000;
        ex(0, 1, 1, 0, 0, 1); tick();
        en_a = 3'b000;

        // ONESHOT up, limit 3, then restart by cfg write
        cfg_a(2, 3, MODE_ONESHOT, DIR_UP);
        ex(0, 2, 0, 0, 0, 0); tick();
        if_a.cfg_we = 1'b0;
        en_a = 3'b100;
        for (int k = 1; k <= 3; k++) begin ex(0, 2, k, 0, 0, 1); tick(); end
        ex(0, 2, 3, 1, 1, 0); tick();
        ex(0, 2, 3, 0, 1, 0); tick();
        cfg_a(2, 3, MODE_ONESHOT, DIR_UP);
        ex(0, 2, 0, 0, 1, 1); tick();
        if_a.cfg_we = 1'b0;
        ex(0, 2, 1, 0, 1, 1); tick();
        en_a = 3'b000;

        // cfg write coincident with terminal cycle; clr coincident with terminal
        cfg_a(1, 2, MODE_WRAP, DIR_UP);
        ex(0, 1, 0, 0, 0, 0); tick();
        if_a.cfg_we = 1'b0;
        en_a = 3'b010;
        ex(0, 1, 1, 0, 0, 1); tick();
        ex(0, 1, 2, 0, 0, 1); tick();
        cfg_a(1, 2, MODE_WRAP, DIR_DN);
        ex(0, 1, 2, 0, 0, 1); tick();
        if_a.cfg_we = 1'b0;
        ex(0, 1, 1, 0, 0, 1); tick();
        ex(0, 1, 0, 0, 0, 1); tick();
        ex(0, 1, 2, 1, 1, 1); tick();
        ex(0, 1, 1, 0, 1, 1); tick();
        ex(0, 1, 0, 0, 1, 1); tick();
        clr_a = 3'b010;
        ex(0, 1, 2, 1, 1, 1); tick();
        clr_a = 3'b000; en_a = 3'b000;
        ex(0, 1, 2, 0, 1, 0); tick();
        clr_a = 3'b010;
        ex(0, 1, 2, 0, 0, 0); tick();
        clr_a = 3'b000;

        // Bank B, STEP=3: SATURATE down from 10, then WRAP up limit 10
        cfg_b(0, 10, MODE_SAT, DIR_DN);
        ex(1, 0, 10, 0, 0, 0); tick();
        if_b.cfg_we = 1'b0;
        en_b = 2'b01;
        ex(1, 0, 7, 0, 0, 1); tick();
        ex(1, 0, 4, 0, 0, 1); tick();
        ex(1, 0, 1, 0, 0, 1); tick();
        for (int k = 0; k < 3; k++) begin ex(1, 0, 0, 1, 1, 1); tick(); end
        en_b = 2'b00;
        ex(1, 0, 0, 0, 1, 0); tick();
        cfg_b(1, 10, MODE_WRAP, DIR_UP);
        ex(1, 1, 0, 0, 0, 0); tick();
        if_b.cfg_we = 1'b0;
        en_b = 2'b10;
        ex(1, 1, 3, 0, 0, 1); tick();
        ex(1, 1, 6, 0, 0, 1); tick();
        ex(1, 1, 9, 0, 0, 1); tick();
        ex(1, 1, 0, 1, 1, 1); tick();
        ex(1, 1, 3, 0, 1, 1); tick();

        // Async reset mid-count, checked before any further clock edge
        en_a = 3'b001; en_b = 2'b11;
        ex(0, 0, 2, 0, 0, 1); ex(1, 0, 0, 1, 1, 1); tick();
        #3 rst_n = 1'b0;
        #1;
        chk("async rst count_a", 32'(count_a), 32'd0);
        chk("async rst count_b", 32'(count_b), 32'd0);
        chk("async rst pulse_a", 32'(pulse_a), 32'd0);
        chk("async rst pulse_b", 32'(pulse_b), 32'd0);
        chk("async rst sticky_a", 32'(sticky_a), 32'd0);
        chk("async rst sticky_b", 32'(sticky_b), 32'd0);
        en_a = '0; en_b = '0;
        #3 rst_n = 1'b1;

        repeat (3) tick();
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
